// File: rtl/spi_master_multi.sv
// spi_master_multi: parametrised SPI master with a configurable word width,
// a runtime clock divider, all four CPOL/CPHA modes, MSB/LSB-first ordering
// and one-hot active-low chip selects that can be held across a burst.
// Optional build macro SPI_MASTER_LOOPBACK_EN adds a loopback input. When
// loopback is set at acceptance, the transfer receives its own mosi instead of miso.
module spi_master_multi #(
   parameter int DATA_W = 8,
   parameter int NUM_CS = 4,
   parameter int DIV_W  = 8,
   localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   input  logic [CS_W-1:0]   cs_sel,
   input  logic              cs_hold,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic [DIV_W-1:0]  clk_div,
   input  logic              miso,
`ifdef SPI_MASTER_LOOPBACK_EN
   input  logic              loopback,
`endif
   output logic              mosi,
   output logic              sck,
   output logic [NUM_CS-1:0] cs_n,
   output logic [DATA_W-1:0] data_out,
   output logic              new_data,
   output logic              busy
);
   localparam int EDGE_W = $clog2(2*DATA_W);
   localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2*DATA_W-1);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
   state_t state_reg, state_next;

   logic [DIV_W-1:0]  div_reg, div_next, cnt_reg, cnt_next;
   logic [EDGE_W-1:0] edge_reg, edge_next;
   logic [DATA_W-1:0] tx_reg, tx_next, rx_reg, rx_next;
   logic [DATA_W-1:0] data_out_reg, data_out_next;
   logic [NUM_CS-1:0] cs_n_reg, cs_n_next, cs_dec;
   logic cpol_reg, cpol_next, cpha_reg, cpha_next, lsb_reg, lsb_next;
   logic hold_reg, hold_next, lb_reg, lb_next, lb_in;
   logic sck_reg, sck_next, mosi_reg, mosi_next, new_data_reg, new_data_next;
   logic tx_bit, rx_bit, din_first;
   logic [DATA_W-1:0] tx_shift, rx_shift, din_shift;

`ifdef SPI_MASTER_LOOPBACK_EN
   assign lb_in = loopback;
`else
   assign lb_in = 1'b0;
`endif

   // Chip-select decode: an out-of-range index leaves every select high
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
         assign cs_dec[gi] = (cs_sel != CS_W'(gi));
      end
   endgenerate

   assign mosi     = mosi_reg;
   assign sck      = sck_reg;
   assign cs_n     = cs_n_reg;
   assign data_out = data_out_reg;
   assign new_data = new_data_reg;
   assign busy     = (state_reg != IDLE);

   // Next-state and datapath logic: phase timing, sck edges, shifting
   always_comb begin
      state_next    = state_reg;
      div_next      = div_reg;
      cnt_next      = cnt_reg;
      edge_next     = edge_reg;
      tx_next       = tx_reg;
      rx_next       = rx_reg;
      cpol_next     = cpol_reg;
      cpha_next     = cpha_reg;
      lsb_next      = lsb_reg;
      hold_next     = hold_reg;
      lb_next       = lb_reg;
      sck_next      = sck_reg;
      mosi_next     = mosi_reg;
      cs_n_next     = cs_n_reg;
      data_out_next = data_out_reg;
      new_data_next = 1'b0;

      // Bit selection follows the latched ordering so data_out ends up unreversed
      tx_bit    = lsb_reg ? tx_reg[0] : tx_reg[DATA_W-1];
      tx_shift  = lsb_reg ? {1'b0, tx_reg[DATA_W-1:1]} : {tx_reg[DATA_W-2:0], 1'b0};
      rx_bit    = lb_reg ? mosi_reg : miso;
      rx_shift  = lsb_reg ? {rx_bit, rx_reg[DATA_W-1:1]} : {rx_reg[DATA_W-2:0], rx_bit};
      din_first = lsb_first ? data_in[0] : data_in[DATA_W-1];
      din_shift = lsb_first ? {1'b0, data_in[DATA_W-1:1]} : {data_in[DATA_W-2:0], 1'b0};

      case (state_reg)
         IDLE: begin
            sck_next = cpol_reg;
            if (start) begin
               div_next   = clk_div;
               cpol_next  = cpol;
               cpha_next  = cpha;
               lsb_next   = lsb_first;
               hold_next  = cs_hold;
               lb_next    = lb_in;
               sck_next   = cpol;
               cs_n_next  = cs_dec;
               cnt_next   = '0;
               edge_next  = '0;
               rx_next    = '0;
               // cpha=0 needs the first bit on the wire before the first leading edge
               if (cpha) begin
                  tx_next   = data_in;
                  mosi_next = 1'b0;
               end else begin
                  tx_next   = din_shift;
                  mosi_next = din_first;
               end
               state_next = SETUP;
            end
         end
         SETUP: begin
            if (cnt_reg == div_reg) begin
               cnt_next   = '0;
               state_next = XFER;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         XFER: begin
            if (cnt_reg == div_reg) begin
               cnt_next  = '0;
               edge_next = edge_reg + 1'b1;
               if (!edge_reg[0]) begin
                  // Leading edge
                  sck_next = ~cpol_reg;
                  if (cpha_reg) begin
                     mosi_next = tx_bit;
                     tx_next   = tx_shift;
                  end else begin
                     rx_next = rx_shift;
                  end
               end else begin
                  // Trailing edge; cpha=0 has no further bit after the last one
                  sck_next = cpol_reg;
                  if (cpha_reg) begin
                     rx_next = rx_shift;
                  end else if (edge_reg != LAST_EDGE) begin
                     mosi_next = tx_bit;
                     tx_next   = tx_shift;
                  end
               end
               if (edge_reg == LAST_EDGE) begin
                  edge_next  = '0;
                  state_next = HOLD;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         HOLD: begin
            if (cnt_reg == div_reg) begin
               cnt_next      = '0;
               data_out_next = rx_reg;
               new_data_next = 1'b1;
               if (!hold_reg) cs_n_next = '1;
               state_next    = IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         div_reg      <= '0;
         cnt_reg      <= '0;
         edge_reg     <= '0;
         tx_reg       <= '0;
         rx_reg       <= '0;
         cpol_reg     <= 1'b0;
         cpha_reg     <= 1'b0;
         lsb_reg      <= 1'b0;
         hold_reg     <= 1'b0;
         lb_reg       <= 1'b0;
         sck_reg      <= 1'b0;
         mosi_reg     <= 1'b0;
         cs_n_reg     <= '1;
         data_out_reg <= '0;
         new_data_reg <= 1'b0;
      end else begin
         div_reg      <= div_next;
         cnt_reg      <= cnt_next;
         edge_reg     <= edge_next;
         tx_reg       <= tx_next;
         rx_reg       <= rx_next;
         cpol_reg     <= cpol_next;
         cpha_reg     <= cpha_next;
         lsb_reg      <= lsb_next;
         hold_reg     <= hold_next;
         lb_reg       <= lb_next;
         sck_reg      <= sck_next;
         mosi_reg     <= mosi_next;
         cs_n_reg     <= cs_n_next;
         data_out_reg <= data_out_next;
         new_data_reg <= new_data_next;
      end
   end
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: directed table-driven bench for spi_master_multi with a
// behavioural SPI slave (mode-aware, MSB/LSB-first) and hand-written sequences
// for burst chip-select hold, mid-transfer abort and ignored start/clk_div.
module tb_spi_master_multi;
   logic       clk = 1'b0;
   logic       rst, start, cs_hold, cpol, cpha, lsb_first, miso;
   logic [7:0] data_in, clk_div;
   logic [1:0] cs_sel;
   logic       mosi, sck, new_data, busy;
   logic [2:0] cs_n;
   logic [7:0] data_out;
`ifdef SPI_MASTER_LOOPBACK_EN
   logic       loopback;
`endif

   spi_master_multi #(.DATA_W(8), .NUM_CS(3), .DIV_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in), .cs_sel(cs_sel),
      .cs_hold(cs_hold), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
      .clk_div(clk_div), .miso(miso),
`ifdef SPI_MASTER_LOOPBACK_EN
      .loopback(loopback),
`endif
      .mosi(mosi), .sck(sck), .cs_n(cs_n), .data_out(data_out),
      .new_data(new_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural slave, armed by toggling arm_tgl
   logic [7:0] arm_word = 8'h00;
   logic       arm_cpol = 1'b0, arm_cpha = 1'b0, arm_lsb = 1'b0, arm_tgl = 1'b0;
   logic       arm_seen = 1'b0, s_active = 1'b0, s_mute = 1'b0, miso_s = 1'b0;
   logic       s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
   logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
   assign miso = s_mute ? 1'b0 : miso_s;

   // Slave: sample mosi on its sample edge, present the next bit on the other edge
   always @(sck or arm_tgl) begin
      if (arm_tgl != arm_seen) begin
         arm_seen = arm_tgl;
         s_tx = arm_word; s_rx = 8'h00;
         s_cpol = arm_cpol; s_cpha = arm_cpha; s_lsb = arm_lsb;
         s_active = 1'b1;
         if (!s_cpha) begin
            miso_s = s_lsb ? s_tx[0] : s_tx[7];
            s_tx = s_lsb ? (s_tx >> 1) : (s_tx << 1);
         end
      end else if (s_active) begin
         if ((sck != s_cpol) == !s_cpha) begin
            s_rx = s_lsb ? {mosi, s_rx[7:1]} : {s_rx[6:0], mosi};
         end else begin
            miso_s = s_lsb ? s_tx[0] : s_tx[7];
            s_tx = s_lsb ? (s_tx >> 1) : (s_tx << 1);
         end
      end
   end

   int n_cmp = 0, n_bad = 0;
   int cyc, busy_cnt, cs_bad;
   logic poke_en = 1'b0;
   logic [2:0] cur_cs;

   typedef struct {
      logic [7:0] din; logic pol; logic pha; logic lsb;
      logic [7:0] div; logic [1:0] sel; logic [7:0] sword;
      logic [7:0] exp_out; int exp_cyc;
   } vec_t;
   vec_t vt [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] cs_exp(input logic [1:0] s);
      return (s < 2'd3) ? ~(3'b001 << s) : 3'b111;
   endfunction

   // Issue a start at the current negedge; returns at the negedge of cycle 1
   task automatic launch(input logic [7:0] din, input logic pol, input logic pha,
                         input logic lsb, input logic [7:0] div, input logic [1:0] sel,
                         input logic hold, input logic [7:0] sword);
      data_in = din; cpol = pol; cpha = pha; lsb_first = lsb;
      clk_div = div; cs_sel = sel; cs_hold = hold; start = 1'b1;
      cur_cs = cs_exp(sel);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      arm_word = sword; arm_cpol = pol; arm_cpha = pha; arm_lsb = lsb;
      arm_tgl = ~arm_tgl;
      cyc = 1;
      busy_cnt = (busy === 1'b1) ? 1 : 0;
      cs_bad = (cs_n !== cur_cs) ? 1 : 0;
      chk("c1_busy", busy, 1);
      chk("c1_sck", sck, pol);
      if (!pha) chk("c1_mosi", mosi, lsb ? din[0] : din[7]);
   endtask

   // Step cycles until new_data (bounded), counting busy and chip-select cycles
   task automatic watch();
      while (new_data !== 1'b1 && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         if (poke_en && cyc == 5) begin
            start = 1'b1; clk_div = 8'd7; data_in = 8'hFF; cs_sel = 2'd1;
         end
         if (poke_en && cyc == 10) start = 1'b0;
         if (new_data !== 1'b1) begin
            busy_cnt += (busy === 1'b1) ? 1 : 0;
            cs_bad   += (cs_n !== cur_cs) ? 1 : 0;
         end
      end
   endtask

   task automatic finish_chk(input string tag, input logic [7:0] exp_out,
                             input logic [7:0] exp_srx, input logic pol,
                             input int exp_cyc, input logic hold);
      chk({tag, "_cyc"}, cyc, exp_cyc);
      chk({tag, "_busy_cycles"}, busy_cnt, exp_cyc - 1);
      chk({tag, "_cs_bad_cycles"}, cs_bad, 0);
      chk({tag, "_new_data"}, new_data, 1);
      chk({tag, "_busy_done"}, busy, 0);
      chk({tag, "_data_out"}, data_out, exp_out);
      chk({tag, "_slave_rx"}, s_rx, exp_srx);
      chk({tag, "_sck_idle"}, sck, pol);
      chk({tag, "_cs_done"}, cs_n, hold ? cur_cs : 3'b111);
      $display("%s: data_out=0x%02h slave_rx=0x%02h done_cycle=%0d cs_n=%b",
               tag, data_out, s_rx, cyc, cs_n);
   endtask

   initial begin
      vt[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 8'h3C, 8'h3C, 37};
      vt[1] = '{8'h81, 1'b0, 1'b1, 1'b0, 8'd1, 2'd1, 8'h81, 8'h81, 37};
      vt[2] = '{8'h81, 1'b1, 1'b0, 1'b0, 8'd1, 2'd2, 8'h81, 8'h81, 37};
      vt[3] = '{8'h81, 1'b1, 1'b1, 1'b0, 8'd1, 2'd0, 8'h81, 8'h81, 37};
      vt[4] = '{8'h01, 1'b0, 1'b0, 1'b1, 8'd1, 2'd0, 8'h80, 8'h80, 37};
      vt[5] = '{8'h2D, 1'b0, 1'b1, 1'b1, 8'd0, 2'd1, 8'hB4, 8'hB4, 19};
      vt[6] = '{8'h6E, 1'b1, 1'b0, 1'b0, 8'd3, 2'd2, 8'h17, 8'h17, 73};
      vt[7] = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'd1, 2'd3, 8'h0F, 8'h0F, 37};
      vt[8] = '{8'hC9, 1'b1, 1'b1, 1'b1, 8'd2, 2'd0, 8'h5A, 8'h5A, 55};

      rst = 1'b1; start = 1'b0; data_in = 8'h00; cs_sel = 2'd0; cs_hold = 1'b0;
      cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd0;
`ifdef SPI_MASTER_LOOPBACK_EN
      loopback = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_sck", sck, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_cs_n", cs_n, 3'b111);
      chk("rst_data_out", data_out, 0);
      chk("rst_new_data", new_data, 0);
      chk("rst_busy", busy, 0);

      for (int i = 0; i < 9; i++) begin
         launch(vt[i].din, vt[i].pol, vt[i].pha, vt[i].lsb, vt[i].div, vt[i].sel,
                1'b0, vt[i].sword);
         watch();
         finish_chk($sformatf("vec%0d", i), vt[i].exp_out, vt[i].din, vt[i].pol,
                    vt[i].exp_cyc, 1'b0);
         @(negedge clk);
         chk($sformatf("vec%0d_pulse_len", i), new_data, 0);
      end

      // start pulses and a clk_div change while busy must not disturb the transfer
      poke_en = 1'b1;
      launch(8'h4B, 1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 1'b0, 8'hB4);
      watch();
      poke_en = 1'b0;
      finish_chk("ignore_busy", 8'hB4, 8'h4B, 1'b0, 37, 1'b0);
      @(negedge clk);
      chk("ignore_busy_no_restart", busy, 0);

      // Burst on cs_sel=2: select held through the first two completions
      launch(8'h11, 1'b0, 1'b0, 1'b0, 8'd1, 2'd2, 1'b1, 8'hE1);
      watch();
      finish_chk("burst0", 8'hE1, 8'h11, 1'b0, 37, 1'b1);
      launch(8'h22, 1'b0, 1'b0, 1'b0, 8'd1, 2'd2, 1'b1, 8'hD2);
      watch();
      finish_chk("burst1", 8'hD2, 8'h22, 1'b0, 37, 1'b1);
      launch(8'h33, 1'b0, 1'b0, 1'b0, 8'd1, 2'd2, 1'b0, 8'hC3);
      watch();
      finish_chk("burst2", 8'hC3, 8'h33, 1'b0, 37, 1'b0);
      @(negedge clk);

      // Abort: reset sampled at the clock edge that would be XFER edge 5 (end of cycle 12)
      launch(8'h96, 1'b1, 1'b0, 1'b0, 8'd1, 2'd1, 1'b0, 8'h69);
      while (cyc < 12) begin
         @(negedge clk);
         cyc++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_cs_n", cs_n, 3'b111);
      chk("abort_sck", sck, 0);
      chk("abort_busy", busy, 0);
      chk("abort_new_data", new_data, 0);
      begin
         int nd_cnt = 0, sck_cnt = 0, busy_seen = 0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            nd_cnt    += (new_data === 1'b1) ? 1 : 0;
            sck_cnt   += (sck !== 1'b0) ? 1 : 0;
            busy_seen += (busy === 1'b1) ? 1 : 0;
         end
         chk("abort_no_pulse", nd_cnt, 0);
         chk("abort_sck_quiet", sck_cnt, 0);
         chk("abort_stays_idle", busy_seen, 0);
      end
      launch(8'h5C, 1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 1'b0, 8'hC5);
      watch();
      finish_chk("after_abort", 8'hC5, 8'h5C, 1'b0, 37, 1'b0);
      @(negedge clk);

`ifdef SPI_MASTER_LOOPBACK_EN
      loopback = 1'b1;
      s_mute = 1'b1;
      launch(8'h5A, 1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 1'b0, 8'h00);
      loopback = 1'b0;
      watch();
      finish_chk("loopback", 8'h5A, 8'h5A, 1'b0, 37, 1'b0);
      s_mute = 1'b0;
      @(negedge clk);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
